// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the slot sensor code, accumulates saturating credit on CIN, clears on Li.
// Optional refund path enabled by defining COIN_REFUND_EN.
module coin_acceptor #(
  parameter int DEB_CYC    = 3,
  parameter int MAX_CREDIT = 7,
  parameter int VAL_A      = 1,
  parameter int VAL_B      = 2,
  parameter int VAL_C      = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] COIN,
  input  logic       Li,
  input  logic       REF,
  output logic [2:0] CIN,
  output logic       FULL,
  output logic       REJ,
  output logic       BUSY,
  output logic       RET
);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, ACCEPT, WAIT_REL, REFUND} state_t;

  state_t     state, state_n;
  logic [1:0] code, code_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] cin, cin_n;
  logic [3:0] val, base, sum;
  logic       rej;
`ifdef COIN_REFUND_EN
  logic       phase, phase_n;
  logic       ret;
`else
  logic       unused_ref;
  assign unused_ref = REF;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      code  <= 2'b00;
      cnt   <= 4'd0;
      cin   <= 3'd0;
`ifdef COIN_REFUND_EN
      phase <= 1'b0;
`endif
    end else begin
      state <= state_n;
      code  <= code_n;
      cnt   <= cnt_n;
      cin   <= cin_n;
`ifdef COIN_REFUND_EN
      phase <= phase_n;
`endif
    end
  end

  always_comb begin
    case (code)
      2'b01:   val = 4'(VAL_A);
      2'b10:   val = 4'(VAL_B);
      2'b11:   val = 4'(VAL_C);
      default: val = 4'd0;
    endcase
  end

  // Li clears before the add, so an accept in the same cycle sees a zero base.
  assign base = Li ? 4'd0 : {1'b0, cin};
  assign sum  = base + val;

  always_comb begin
    state_n = state;
    code_n  = code;
    cnt_n   = cnt;
    cin_n   = Li ? 3'd0 : cin;
    rej     = 1'b0;
`ifdef COIN_REFUND_EN
    phase_n = phase;
    ret     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef COIN_REFUND_EN
        if (REF && cin != 3'd0 && !Li) begin
          state_n = REFUND;
          phase_n = 1'b0;
        end else
`endif
        if (COIN != 2'b00) begin
          code_n  = COIN;
          cnt_n   = 4'd1;
          state_n = (DEB_CYC == 1) ? ACCEPT : DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (COIN == code) begin
          cnt_n = cnt + 4'd1;
          if (cnt + 4'd1 == 4'(DEB_CYC)) state_n = ACCEPT;
        end else begin
          state_n = IDLE;
        end
      end
      ACCEPT: begin
        if (sum <= 4'(MAX_CREDIT)) cin_n = sum[2:0];
        else                       rej   = 1'b1;
        state_n = WAIT_REL;
      end
      WAIT_REL: begin
        if (COIN == 2'b00) state_n = IDLE;
      end
`ifdef COIN_REFUND_EN
      REFUND: begin
        if (Li) begin
          state_n = IDLE;
        end else if (!phase) begin
          ret     = 1'b1;
          cin_n   = cin - 3'd1;
          phase_n = 1'b1;
        end else if (cin == 3'd0) begin
          state_n = IDLE;
        end else begin
          phase_n = 1'b0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign CIN  = cin;
  assign FULL = (cin == 3'(MAX_CREDIT));
  assign REJ  = rej;
  assign BUSY = (state != IDLE);
`ifdef COIN_REFUND_EN
  assign RET  = ret;
`else
  assign RET  = 1'b0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios with literal credit checks, then random stimulus
// compared every cycle against a behavioural credit/debounce model.
module tb_coin_acceptor;
  localparam int DEB = 3, MAX = 7, VA = 1, VB = 2, VC = 5;
  localparam int M_IDLE = 0, M_DEB = 1, M_ACC = 2, M_REL = 3, M_REF = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] COIN = 2'b00;
  logic       Li = 1'b0;
  logic       REF = 1'b0;
  logic [2:0] CIN;
  logic       FULL, REJ, BUSY, RET;

  int checks = 0, failures = 0;
  int rej_seen = 0, ret_seen = 0;

  // behavioural model
  int m_mode = M_IDLE, m_credit = 0, m_code = 0, m_run = 0;
  bit m_rph = 1'b0;

  coin_acceptor #(.DEB_CYC(DEB), .MAX_CREDIT(MAX), .VAL_A(VA), .VAL_B(VB), .VAL_C(VC)) dut (
    .CLK(CLK), .RESET(RESET), .COIN(COIN), .Li(Li), .REF(REF),
    .CIN(CIN), .FULL(FULL), .REJ(REJ), .BUSY(BUSY), .RET(RET)
  );

  always #5 CLK = ~CLK;

  function automatic int val(int c);
    case (c)
      1: return VA;
      2: return VB;
      3: return VC;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge CLK or posedge RESET) begin
    int base;
    if (RESET) begin
      m_mode = M_IDLE; m_credit = 0; m_code = 0; m_run = 0; m_rph = 1'b0;
    end else begin
      base = Li ? 0 : m_credit;
      case (m_mode)
        M_IDLE: begin
          m_credit = base;
`ifdef COIN_REFUND_EN
          if (REF && base > 0) begin
            m_mode = M_REF; m_rph = 1'b0;
          end else
`endif
          if (COIN != 0) begin
            m_code = COIN; m_run = 1;
            m_mode = (m_run >= DEB) ? M_ACC : M_DEB;
          end
        end
        M_DEB: begin
          m_credit = base;
          if (COIN == m_code) begin
            m_run++;
            if (m_run >= DEB) m_mode = M_ACC;
          end else m_mode = M_IDLE;
        end
        M_ACC: begin
          m_credit = (base + val(m_code) <= MAX) ? base + val(m_code) : base;
          m_mode = M_REL;
        end
        M_REL: begin
          m_credit = base;
          if (COIN == 0) m_mode = M_IDLE;
        end
        M_REF: begin
          if (Li) begin m_credit = 0; m_mode = M_IDLE; end
          else if (!m_rph) begin m_credit--; m_rph = 1'b1; end
          else if (m_credit == 0) m_mode = M_IDLE;
          else m_rph = 1'b0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge CLK) begin
    int exp_rej, exp_ret;
    #2;
    exp_rej = (m_mode == M_ACC && ((Li ? 0 : m_credit) + val(m_code) > MAX)) ? 1 : 0;
`ifdef COIN_REFUND_EN
    exp_ret = (m_mode == M_REF && !m_rph && !Li && !RESET) ? 1 : 0;
`else
    exp_ret = 0;
`endif
    chk("cin",  int'(CIN),  m_credit);
    chk("full", int'(FULL), (m_credit == MAX) ? 1 : 0);
    chk("busy", int'(BUSY), (m_mode != M_IDLE) ? 1 : 0);
    chk("rej",  int'(REJ),  exp_rej);
    chk("ret",  int'(RET),  exp_ret);
    if (REJ) rej_seen++;
    if (RET) ret_seen++;
  end

  task automatic cyc(input int c, input bit l, input bit r, input int n);
    repeat (n) begin
      @(negedge CLK);
      COIN = 2'(c); Li = l; REF = r;
    end
  endtask

  task automatic coin(input int c);
    cyc(c, 0, 0, 5);
    cyc(0, 0, 0, 2);
  endtask

  task automatic lit(string name, int exp);
    #3;
    chk({name, "_dut"}, int'(CIN), exp);
    chk({name, "_model"}, m_credit, exp);
  endtask

  initial begin
    cyc(0, 0, 0, 2);
    RESET = 1'b0;
    cyc(0, 0, 0, 1);
    lit("reset", 0);

    rej_seen = 0;
    cyc(1, 0, 0, 6); cyc(0, 0, 0, 2);
    lit("coin_a", 1);
    chk("coin_a_rej", rej_seen, 0);

    cyc(0, 1, 0, 1); cyc(0, 0, 0, 1);
    cyc(2, 0, 0, 2); cyc(0, 0, 0, 3);
    lit("glitch", 0);
    chk("glitch_busy", int'(BUSY), 0);

    coin(3);
    lit("coin_c", 5);
    coin(2);
    lit("coin_b_full", 7);
    chk("full_lit", int'(FULL), 1);
    rej_seen = 0;
    coin(1);
    lit("overflow", 7);
    chk("overflow_rej", rej_seen, 1);

    cyc(0, 1, 0, 1); cyc(0, 0, 0, 1);
    lit("li_clear", 0);
    chk("li_full", int'(FULL), 0);

    coin(3); coin(2);
    rej_seen = 0;
    cyc(3, 0, 0, 3); cyc(3, 1, 0, 1); cyc(3, 0, 0, 2); cyc(0, 0, 0, 2);
    lit("li_accept", 5);
    chk("li_accept_rej", rej_seen, 0);

    cyc(1, 0, 0, 20); cyc(0, 0, 0, 2);
    lit("held", 6);

`ifdef COIN_REFUND_EN
    cyc(0, 1, 0, 1); coin(2); coin(1);
    lit("pre_refund", 3);
    ret_seen = 0;
    cyc(0, 0, 1, 1); cyc(0, 0, 0, 8);
    lit("refund", 0);
    chk("refund_ret", ret_seen, 3);
    chk("refund_idle", int'(BUSY), 0);

    coin(2); coin(1);
    cyc(0, 0, 1, 1); cyc(0, 0, 0, 2);
    #1 RESET = 1'b1;
    #1;
    chk("rst_cin", int'(CIN), 0);
    chk("rst_ret", int'(RET), 0);
    @(negedge CLK) RESET = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) COIN = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom_range(3));
      Li    = ($urandom_range(39) == 0);
      REF   = ($urandom_range(24) == 0);
      RESET = ($urandom_range(499) == 0);
    end
    @(negedge CLK);
    RESET = 1'b0; COIN = 2'b00; Li = 1'b0; REF = 1'b0;
    repeat (2) @(negedge CLK);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front end of the vending path. Debounces a coin-slot sensor code, accumulates credit, and drives the 3-bit credit bus CIN that FSMdisp consumes.
- Clears credit when the dispenser signals vend completion on Li.
- Sits between the coin-slot sensor and FSMdisp, and is clocked by the FSM clock.

Parameters:
- DEB_CYC, 3, number of consecutive cycles a nonzero coin code must be stable before it is accepted (1..15).
- MAX_CREDIT, 7, credit saturation ceiling (must be <= 7 to fit CIN).
- VAL_A, 1, credit units for coin code 2'b01.
- VAL_B, 2, credit units for coin code 2'b10.
- VAL_C, 5, credit units for coin code 2'b11.

Ports:
- CLK  input  1  FSM clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- COIN  input  2  raw slot sensor code: 00 = no coin, 01/10/11 = coin types A/B/C.
- Li  input  1  vend-complete from FSMdisp; high clears credit.
- REF  input  1  refund request (used only with COIN_REFUND_EN).
- CIN  output  3  accumulated credit to FSMdisp.
- FULL  output  1  high while CIN == MAX_CREDIT.
- REJ  output  1  one-cycle pulse when a coin is rejected.
- BUSY  output  1  high in any state other than IDLE.
- RET  output  1  refund coin-eject pulse (COIN_REFUND_EN only).

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high on RESET. Reset forces state IDLE, CIN = 0, debounce count = 0, REJ = 0, RET = 0, BUSY = 0, FULL = 0. Reset mid-operation abandons the coin in progress; no REJ is issued.
- States: IDLE, DEBOUNCE, ACCEPT, WAIT_REL, plus REFUND when the feature is enabled.
- IDLE -> DEBOUNCE: when COIN != 00. Latch the code and set the count to 1.
- DEBOUNCE:
  - COIN equals the latched code: increment the count. When count == DEB_CYC, go to ACCEPT.
  - COIN differs (including 00): return to IDLE with no credit change. This is a glitch and produces no REJ.
- ACCEPT (exactly one cycle): let v be the unit value of the latched code.
  - CIN + v <= MAX_CREDIT: CIN <= CIN + v.
  - Otherwise: CIN unchanged and REJ = 1 for this cycle. The coin is returned physically.
  - Always go to WAIT_REL next.
- WAIT_REL: stay until COIN == 00 for one sampled cycle, then go to IDLE. A held coin is never counted twice.
- Latency: credit updates DEB_CYC+1 rising edges after COIN first becomes stable and nonzero. Example: with DEB_CYC = 3, CIN changes on the 4th edge.
- Li clear: Li high forces CIN <= 0 in any state. It does not change the FSM state.
- Li and ACCEPT in the same cycle: the clear applies first, then the add, so CIN <= v. REJ follows the same rule evaluated against 0, so it is never asserted in that cycle.
- Arithmetic: the sum is computed 4 bits wide to detect overflow. CIN never exceeds MAX_CREDIT and never wraps.
- FULL: combinational from CIN.
- BUSY: combinational from state.

Optional Feature:
- Macro: COIN_REFUND_EN.
- Defined:
  - In IDLE, REF high with CIN > 0 enters REFUND.
  - REFUND emits RET high for 1 cycle and low for 1 cycle, decrementing CIN by 1 on each RET-high cycle.
  - When CIN reaches 0, return to IDLE.
  - Coin inputs are ignored during REFUND.
  - Li during REFUND clears CIN and returns to IDLE.
  - REF with CIN == 0 is ignored.
- Not defined: the REF port exists but is ignored, RET is tied 0, and there is no REFUND state.

Test Plan:
- Reset then COIN = 01 held 6 cycles, then 00 -> CIN = 1 at the 4th edge after the code appears; BUSY is high during DEBOUNCE, ACCEPT and WAIT_REL; no REJ.
- COIN = 10 pulsed for 2 cycles only -> CIN stays 0, REJ stays 0, state returns to IDLE.
- Coins 11 then 10 (each stable 4+ cycles, released between) -> CIN = 5, then 7 with FULL = 1. A further coin 01 -> REJ pulses once and CIN stays 7.
- CIN = 7 and Li pulsed 1 cycle -> CIN = 0 and FULL = 0 on the next edge. Li coincident with the ACCEPT of coin 11 -> CIN = 5 and REJ = 0.
- COIN = 01 held 20 cycles continuously -> CIN increments once only (1).
- With COIN_REFUND_EN, CIN = 3, REF pulsed -> three RET pulses on alternating cycles, CIN goes 2, 1, 0, then IDLE. RESET asserted mid-refund -> CIN = 0 and RET = 0 immediately.
